// File: rtl/cronometro_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding and the
// per-digit moduli (cs units, cs tens, s units, s tens, min units, min tens).
package cronometro_pkg;

  typedef enum logic {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  localparam int unsigned MOD_CS_U = 10;
  localparam int unsigned MOD_CS_D = 10;
  localparam int unsigned MOD_S_U  = 10;
  localparam int unsigned MOD_S_D  = 6;
  localparam int unsigned MOD_M_U  = 10;
  localparam int unsigned MOD_M_D  = 6;

endpackage

// File: rtl/contador_bcd.sv
// One decimal digit of the stopwatch: counts 0..MODULO-1 on en, clears on clr,
// and raises co combinationally on the enable that wraps it.
module contador_bcd #(
  parameter int unsigned MODULO = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       co
);

  assign co = en && (q == 4'(MODULO - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= co ? 4'd0 : q + 4'd1;
  end

endmodule

// File: rtl/cronometro_bcd.sv
// mm:ss.cc BCD stopwatch with run/stop, clear and an optional lap freeze
// (lap feature compiled in only with macro CRONOMETRO_VOLTA_EN).
module cronometro_bcd
  import cronometro_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       zerar,
  input  logic       volta,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic       rodando,
  output logic       estouro
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  estado_t       estado;
  logic [PW-1:0] presc;
  logic          ss_r, ss_p, zr_r, zr_p, vt_r, vt_p;
  logic          ss_edge, zr_edge, vt_edge, ss_act, tick;
  logic [3:0]    q0, q1, q2, q3, q4, q5;
  logic          c0, c1, c2, c3, c4, c5;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ss_r, ss_p, zr_r, zr_p, vt_r, vt_p} <= '0;
    end else begin
      ss_r <= start_stop;
      ss_p <= ss_r;
      zr_r <= zerar;
      zr_p <= zr_r;
      vt_r <= volta;
      vt_p <= vt_r;
    end
  end

  assign ss_edge = ss_r & ~ss_p;
  assign zr_edge = zr_r & ~zr_p;
  assign vt_edge = vt_r & ~vt_p;
  // A clear swallows a coincident run/stop request.
  assign ss_act  = ss_edge & ~zr_edge;
  assign tick    = (estado == CONTANDO) && (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= PARADO;
      rodando <= 1'b0;
      estouro <= 1'b0;
    end else begin
      estouro <= c5;
      if (ss_act) begin
        estado  <= (estado == PARADO) ? CONTANDO : PARADO;
        rodando <= (estado == PARADO);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || zr_edge)         presc <= '0;
    else if (estado == CONTANDO) presc <= tick ? '0 : presc + 1'b1;
  end

  contador_bcd #(.MODULO(MOD_CS_U)) u_dig0 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(tick & ~zr_edge), .q(q0), .co(c0));
  contador_bcd #(.MODULO(MOD_CS_D)) u_dig1 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(c0), .q(q1), .co(c1));
  contador_bcd #(.MODULO(MOD_S_U))  u_dig2 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(c1), .q(q2), .co(c2));
  contador_bcd #(.MODULO(MOD_S_D))  u_dig3 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(c2), .q(q3), .co(c3));
  contador_bcd #(.MODULO(MOD_M_U))  u_dig4 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(c3), .q(q4), .co(c4));
  contador_bcd #(.MODULO(MOD_M_D))  u_dig5 (.clk(clk), .rst(rst), .clr(zr_edge),
    .en(c4), .q(q5), .co(c5));

`ifdef CRONOMETRO_VOLTA_EN
  logic       congelado;
  logic [3:0] lap [6];

  always_ff @(posedge clk) begin
    if (rst || zr_edge) begin
      congelado <= 1'b0;
    end else if (estado == CONTANDO) begin
      if (ss_act)       congelado <= 1'b0;
      else if (vt_edge) congelado <= ~congelado;
    end
  end

  // NOTE: the lap snapshot needs no reset; it is only visible while congelado is set.
  always_ff @(posedge clk) begin
    if ((estado == CONTANDO) && !ss_act && !zr_edge && vt_edge && !congelado)
      lap <= '{q0, q1, q2, q3, q4, q5};
  end

  assign dig0 = congelado ? lap[0] : q0;
  assign dig1 = congelado ? lap[1] : q1;
  assign dig2 = congelado ? lap[2] : q2;
  assign dig3 = congelado ? lap[3] : q3;
  assign dig4 = congelado ? lap[4] : q4;
  assign dig5 = congelado ? lap[5] : q5;
`else
  logic unused_volta;
  assign unused_volta = vt_edge;

  assign dig0 = q0;
  assign dig1 = q1;
  assign dig2 = q2;
  assign dig3 = q3;
  assign dig4 = q4;
  assign dig5 = q5;
`endif

endmodule

// File: tb/tb_cronometro_bcd.sv
// Bench for cronometro_bcd (10 clocks per tick): directed table, corner-case
// sequences and random stimulus against a centisecond-integer reference model.
module tb_cronometro_bcd;

  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int FULL     = 360000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start_stop = 1'b0, zerar = 1'b0, volta = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5;
  logic       rodando, estouro;
  logic [23:0] disp;
  assign disp = {dig5, dig4, dig3, dig2, dig1, dig0};

  cronometro_bcd #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .zerar(zerar), .volta(volta),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5),
    .rodando(rodando), .estouro(estouro)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: elapsed time as a plain centisecond count.
  bit       m_run, m_frz, m_est;
  int       m_cs, m_presc, m_lap;
  bit [2:0] h1, h2;  // input history {volta, zerar, start_stop}
  logic [3:0] p0, p1, p2, p3, p4, p5;

  function automatic logic [23:0] to_bcd(input int cs);
    int secs, mins;
    secs = (cs / 100) % 60;
    mins = (cs / 6000) % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit z, input bit v, input bit r);
    bit [2:0] e;
    bit       tk;
    if (r) begin
      m_run = 0; m_frz = 0; m_est = 0; m_cs = 0; m_presc = 0; h1 = '0; h2 = '0;
    end else begin
      e  = h1 & ~h2;
      h2 = h1;
      h1 = {v, z, s};
      tk = m_run && (m_presc == DIV - 1);
      m_est = 0;
      if (e[1]) begin
        m_cs = 0; m_presc = 0; m_frz = 0;
      end else begin
        if (m_run) m_presc = (m_presc + 1) % DIV;
`ifdef CRONOMETRO_VOLTA_EN
        if (m_run && e[0]) m_frz = 0;
        else if (m_run && e[2]) begin
          if (!m_frz) begin m_lap = m_cs; m_frz = 1; end
          else m_frz = 0;
        end
`endif
        if (tk) begin
          m_cs++;
          if (m_cs == FULL) begin m_cs = 0; m_est = 1; end
        end
        if (e[0]) m_run = !m_run;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit z, input bit v, input bit r);
    @(negedge clk);
    start_stop = s; zerar = z; volta = v; rst = r;
    @(posedge clk);
    model_step(s, z, v, r);
    #1;
    check("model_digits", int'(disp), int'(to_bcd(m_frz ? m_lap : m_cs)));
    check("model_rodando", int'(rodando), int'(m_run));
    check("model_estouro", int'(estouro), int'(m_est));
  endtask

  // Jump the live count to a given value between clock edges.
  task automatic preload(input int cs);
    {p5, p4, p3, p2, p1, p0} = to_bcd(cs);
    #1;
    force dut.u_dig0.q = p0; force dut.u_dig1.q = p1; force dut.u_dig2.q = p2;
    force dut.u_dig3.q = p3; force dut.u_dig4.q = p4; force dut.u_dig5.q = p5;
    #1;
    release dut.u_dig0.q; release dut.u_dig1.q; release dut.u_dig2.q;
    release dut.u_dig3.q; release dut.u_dig4.q; release dut.u_dig5.q;
    m_cs = cs;
  endtask

  typedef struct {
    string name;
    bit    ss, zr, rs;
    int    n;
    int    cs;
    bit    run;
  } vec_t;

  vec_t vecs [10];
  bit   found;

  initial begin
    vecs[0] = '{"reset",        0, 0, 1,    3,   0, 0};
    vecs[1] = '{"start_seen",   1, 0, 0,    1,   0, 0};
    vecs[2] = '{"start_acted",  0, 0, 0,    1,   0, 1};
    vecs[3] = '{"count_1s",     0, 0, 0, 1000, 100, 1};
    vecs[4] = '{"zerar_seen",   0, 1, 0,    1, 100, 1};
    vecs[5] = '{"zerar_acted",  0, 0, 0,    1,   0, 1};
    vecs[6] = '{"stop_seen",    1, 0, 0,    1,   0, 1};
    vecs[7] = '{"stop_acted",   0, 0, 0,    1,   0, 0};
    vecs[8] = '{"idle_stopped", 0, 0, 0,   50,   0, 0};
    vecs[9] = '{"restart",      1, 0, 0,    2,   0, 1};

    foreach (vecs[i]) begin
      repeat (vecs[i].n) cyc(vecs[i].ss, vecs[i].zr, 1'b0, vecs[i].rs);
      check({vecs[i].name, "_digits"}, int'(disp), int'(to_bcd(vecs[i].cs)));
      check({vecs[i].name, "_rodando"}, int'(rodando), int'(vecs[i].run));
      check({vecs[i].name, "_estouro"}, int'(estouro), 0);
    end

    // Wrap from 59:59.99 while running.
    preload(FULL - 1);
    found = 0;
    for (int i = 0; i < DIV + 2 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (estouro) found = 1;
    end
    check("wrap_estouro_seen", int'(found), 1);
    check("wrap_digits", int'(disp), 0);
    cyc(0, 0, 0, 0);
    check("wrap_estouro_one_cycle", int'(estouro), 0);
    check("wrap_still_running", int'(rodando), 1);

    // Coincident start_stop and zerar at 00:12.34.
    preload(1234);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("coincide_digits", int'(disp), 0);
    check("coincide_rodando", int'(rodando), 1);

    // Stop at 00:00.05 with prescaler at 7, then restart.
    cyc(0, 1, 0, 0);
    repeat (56) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("stop_digits", int'(disp), int'(to_bcd(5)));
    check("stop_rodando", int'(rodando), 0);
    check("stop_prescaler", int'(dut.presc), 7);
    repeat (50) cyc(0, 0, 0, 0);
    check("stopped_hold", int'(disp), int'(to_bcd(5)));
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("restart_rodando", int'(rodando), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("restart_before_tick", int'(disp), int'(to_bcd(5)));
    cyc(0, 0, 0, 0);
    check("restart_tick_3", int'(disp), int'(to_bcd(6)));

    // Reset mid-count at 03:21.09.
    preload(20109);
    cyc(0, 0, 0, 1);
    check("rst_digits", int'(disp), 0);
    check("rst_rodando", int'(rodando), 0);
    check("rst_estouro", int'(estouro), 0);
    cyc(0, 0, 0, 0);

`ifdef CRONOMETRO_VOLTA_EN
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (2000) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (499) cyc(0, 0, 0, 0);
    check("lap_frozen", int'(disp), int'(to_bcd(200)));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("lap_released", int'(disp), int'(to_bcd(250)));
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(39) == 0, $urandom_range(199) == 0,
          $urandom_range(59) == 0, $urandom_range(499) == 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cronometro_bcd.md
CRONOMETRO_BCD -- requirements
Module: cronometro_bcd

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count rate in Hz (one centisecond per tick).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_stop  input  1  level from debounced key; rising edge toggles run/stop.
REQ-006 SHALL have port zerar  input  1  level; rising edge clears the count.
REQ-007 SHALL have port volta  input  1  level; rising edge toggles lap-freeze (used only with CRONOMETRO_VOLTA_EN).
REQ-008 SHALL have port dig0..dig5  output  4 each  BCD digits: centiseconds units/tens, seconds units/tens, minutes units/tens; each feeds one seven-segment decoder.
REQ-009 SHALL have port rodando  output  1  high while in state CONTANDO.
REQ-010 SHALL have port estouro  output  1  one-cycle pulse on wrap from 59:59.99.

Function
REQ-011 SHALL detect rising edges of start_stop, zerar and volta by registering each input once and comparing against the previous value; an edge is acted on in the cycle after it is seen.
REQ-012 SHALL implement FSM states PARADO and CONTANDO; PARADO + start_stop edge -> CONTANDO; CONTANDO + start_stop edge -> PARADO.
REQ-013 SHALL run a prescaler from 0 to CLK_FREQ/TICK_HZ-1 only in CONTANDO, producing one tick per wrap; the prescaler holds its value in PARADO.
REQ-014 SHALL increment the count by one centisecond per tick, using moduli 10,10,10,6,10,6 for dig0..dig5, with carry propagated in the same cycle.
REQ-015 SHALL wrap 59:59.99 -> 00:00.00 on a tick, pulse estouro for that cycle, and remain in CONTANDO.
REQ-016 SHALL, on a zerar edge, clear all digits, the prescaler and the lap freeze, while leaving the FSM state unchanged.
REQ-017 SHALL give zerar priority when zerar and start_stop edges coincide; the start_stop edge is discarded.
REQ-018 SHALL suppress a tick that coincides with a zerar edge; the count becomes 00:00.00.
REQ-019 SHALL apply a tick in the same cycle as a CONTANDO->PARADO transition.
REQ-020 SHALL always hold every digit output in the range 0 to its modulus-1.

Reset
REQ-021 SHALL, on rst high at a clock edge, set state PARADO, all digits 0, prescaler 0, estouro 0, rodando 0, lap freeze off, and edge registers to 0.
REQ-022 SHALL give rst priority over all other inputs, including reset asserted mid-count.

Configuration
REQ-023 SHALL compile the lap feature in only when macro CRONOMETRO_VOLTA_EN is defined.
REQ-024 SHALL, with CRONOMETRO_VOLTA_EN defined: while CONTANDO, a volta edge latches the live count into dig0..dig5 and freezes them; internal counting continues; a second volta edge, or a transition to PARADO, releases the freeze and shows the live count.
REQ-025 SHALL, without CRONOMETRO_VOLTA_EN: keep the volta port present but ignore it; dig0..dig5 always show the live count.

Structure
REQ-026 SHALL place the FSM state encodings (PARADO, CONTANDO) and the digit moduli constants in shared package cronometro_pkg.
REQ-027 SHALL instantiate sub-module contador_bcd six times: one digit each, with a modulus parameter, inputs clk, rst, clr and en (carry-in), and outputs q[3:0] and carry-out (en and q==modulus-1).

Verification
Bench parameters: CLK_FREQ=1000, TICK_HZ=100, giving 10 cycles per tick.
REQ-028 SHALL verify basic count: reset, start_stop edge, 100 ticks -> digits 00:01.00 and rodando=1.
REQ-029 SHALL verify wrap: preload 59:59.99 by running, then 1 tick -> 00:00.00 with estouro high for exactly one cycle.
REQ-030 SHALL verify simultaneous edges: start_stop and zerar rise in the same cycle while CONTANDO at 00:12.34 -> 00:00.00, still CONTANDO.
REQ-031 SHALL verify stop/restart: stop at 00:00.05 with prescaler at 7; 50 idle cycles -> digits unchanged; restart -> next tick after 3 cycles.
REQ-032 SHALL verify reset mid-count: rst at 03:21.09 -> next cycle all zero, PARADO, rodando=0.
REQ-033 SHALL verify lap (CRONOMETRO_VOLTA_EN): volta edge at 00:02.00, 50 ticks -> outputs stay 00:02.00; second volta edge -> outputs show 00:02.50.
